riscv_muldiv_unit: RTL and testbench

// - Iterative RV32M/RV64M multiply/divide unit sitting beside the main ALU in the EX stage.
// - Decodes Funct3 of an M-extension R-type instruction and runs a bit-serial shift-add

---
 rtl/riscv_muldiv_unit_if.sv | 25 ++
 rtl/riscv_muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_muldiv_unit_if.sv
// Handshake bundle between the EX-stage controller and the
// iterative multiply/divide unit.
interface riscv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            ready;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] Result;

    modport master (
        output start, flush, Funct3, SrcA, SrcB,
        input  ready, busy, done, Result
    );

    modport slave (
        input  start, flush, Funct3, SrcA, SrcB,
        output ready, busy, done, Result
    );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply (shift-add) / restoring divide unit.
// Optional MULDIV_EARLY_OUT_EN: trivial operands skip the iteration loop.
module riscv_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input logic                clk,
    input logic                reset,
    riscv_muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] prod_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              negp_q;
    logic              negr_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    // Launch-time operand decode
    logic              is_div;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic              b_zero;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN-1:0]   mcand_ld;
    logic [2*XLEN-1:0] prod_ld;
    logic              negp_ld;

    assign is_div   = bus.Funct3[2];
    assign a_signed = is_div ? ~bus.Funct3[0]
                             : (bus.Funct3[1:0] != 2'b11);
    assign b_signed = is_div ? ~bus.Funct3[0] : ~bus.Funct3[1];
    assign a_neg    = a_signed & bus.SrcA[XLEN-1];
    assign b_neg    = b_signed & bus.SrcB[XLEN-1];
    assign b_zero   = (bus.SrcB == '0);
    assign abs_a    = a_neg ? -bus.SrcA : bus.SrcA;
    assign abs_b    = b_neg ? -bus.SrcB : bus.SrcB;
    assign mcand_ld = is_div ? abs_b : abs_a;
    assign prod_ld  = {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
    // Divide by zero keeps the all-ones quotient unsigned.
    assign negp_ld  = (a_neg ^ b_neg) & ~(is_div & b_zero);

    // One iteration of either datapath
    logic [XLEN:0]     msum;
    logic [2*XLEN-1:0] mul_nx;
    logic [XLEN:0]     shr;
    logic              ge;
    logic [XLEN-1:0]   diff;
    logic [2*XLEN-1:0] div_nx;
    logic [2*XLEN-1:0] step;

    assign msum   = {1'b0, prod_q[2*XLEN-1:XLEN]}
                  + (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    assign mul_nx = {msum, prod_q[XLEN-1:1]};
    assign shr    = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    assign ge     = (shr >= {1'b0, mcand_q});
    assign diff   = shr[XLEN-1:0] - mcand_q;
    assign div_nx = {(ge ? diff : shr[XLEN-1:0]),
                     prod_q[XLEN-2:0], ge};
    assign step   = op_q[2] ? div_nx : mul_nx;

    // Sign fix and result selection on the last iteration
    logic [2*XLEN-1:0] pfix;
    logic [XLEN-1:0]   qfix;
    logic [XLEN-1:0]   rfix;
    logic [XLEN-1:0]   fin_res;

    always_comb begin
        pfix = negp_q ? -step : step;
        qfix = negp_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        rfix = negr_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            fin_res = op_q[1] ? rfix : qfix;
        end else begin
            fin_res = (op_q[1:0] == 2'b00) ? pfix[XLEN-1:0]
                                           : pfix[2*XLEN-1:XLEN];
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            early_ld;
    logic [XLEN-1:0] early_res;
    logic            ovf;

    // Results for operand patterns that need no iteration
    always_comb begin
        ovf = is_div & ~bus.Funct3[0]
            & (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}})
            & (bus.SrcB == {XLEN{1'b1}});
        early_ld  = 1'b0;
        early_res = '0;
        if (is_div) begin
            if (b_zero) begin
                early_ld  = 1'b1;
                early_res = bus.Funct3[1] ? bus.SrcA : {XLEN{1'b1}};
            end else if (ovf) begin
                early_ld  = 1'b1;
                early_res = bus.Funct3[1] ? '0 : bus.SrcA;
            end
        end else if ((bus.SrcA == '0) || b_zero) begin
            early_ld  = 1'b1;
            early_res = '0;
        end
    end
`endif

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            negp_q   <= 1'b0;
            negr_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, FIN: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q    <= bus.Funct3;
                        mcand_q <= mcand_ld;
                        prod_q  <= prod_ld;
                        negp_q  <= negp_ld;
                        negr_q  <= a_neg;
                        cnt_q   <= CNT_W'(XLEN-1);
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_ld) begin
                            state_q  <= FIN;
                            done_q   <= 1'b1;
                            result_q <= early_res;
                        end else begin
                            state_q <= CALC;
                        end
`else
                        state_q <= CALC;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    prod_q <= step;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q  <= FIN;
                        done_q   <= 1'b1;
                        result_q <= fin_res;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready  = (state_q == IDLE) || (state_q == FIN);
    assign bus.busy   = (state_q == CALC) || (state_q == FIN);
    assign bus.done   = done_q;
    assign bus.Result = result_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit: vector table,
// scoreboard queue, and flush/reset/back-to-back sequences.
module tb_riscv_muldiv_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    riscv_muldiv_unit_if #(.XLEN(XLEN)) bus ();

    riscv_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ex;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          c0;
        int          lat;
    } sb_t;

    sb_t  sbq[$];
    vec_t vt[$];
    sb_t  mon_e;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (f3[2]) begin
            if (b == 0) return 1;
            if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return 1;
        end else if (a == 0 || b == 0) begin
            return 1;
        end
`endif
        return XLEN + 1;
    endfunction

    // Scoreboard: every done pulse must match the oldest launch
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("result", bus.Result, mon_e.res);
                chk("latency", cyc - mon_e.c0, mon_e.lat);
            end
        end
    end

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready"}, bus.ready, 1);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ex,
                          input string nm);
        int  lat;
        int  bcnt = 0;
        bit  seen = 0;
        wait_ready(nm);
        lat = exp_lat(f3, a, b);
        bus.Funct3 = f3;
        bus.SrcA   = a;
        bus.SrcB   = b;
        bus.start  = 1'b1;
        sbq.push_back('{ex, cyc, lat});
        @(negedge clk);
        bus.start  = 1'b0;
        bus.Funct3 = ~f3;
        bus.SrcA   = ~a;
        bus.SrcB   = b + 32'd1;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (bus.busy) bcnt++;
            if (bus.done) seen = 1;
            else @(negedge clk);
        end
        chk({nm, "_done_seen"}, seen, 1);
        chk({nm, "_busy_cycles"}, bcnt, lat);
        @(negedge clk);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_seen"}, bus.done, 1);
    endtask

    task automatic quiet(input string nm, input int ncyc);
        int d = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.done) d++;
        end
        chk({nm, "_no_done"}, d, 0);
    endtask

    initial begin
        logic [63:0] p;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] ex;
        logic [2:0]  f3;

        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.Funct3 = 3'b000;
        bus.SrcA   = '0;
        bus.SrcB   = '0;

        vt.push_back('{3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB});
        vt.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        vt.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vt.push_back('{3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF});
        vt.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
        vt.push_back('{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001});
        vt.push_back('{3'b000, 32'd0,         32'd5,         32'h0000_0000});
        vt.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
        vt.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
        vt.push_back('{3'b101, 32'd100,       32'd7,         32'd14});
        vt.push_back('{3'b111, 32'd100,       32'd7,         32'd2});
        vt.push_back('{3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3});
        vt.push_back('{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1});
        vt.push_back('{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF});
        vt.push_back('{3'b110, 32'd5,         32'd0,         32'd5});
        vt.push_back('{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB});
        vt.push_back('{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF});
        vt.push_back('{3'b111, 32'd5,         32'd0,         32'd5});
        vt.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vt.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
        vt.push_back('{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF});

        repeat (3) @(negedge clk);
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.Result, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vt.size(); i++)
            run_op(vt[i].f3, vt[i].a, vt[i].b, vt[i].ex,
                   $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom_range(32'h0001_FFFF, 1);
            p  = 64'(ra) * 64'(rb);
            case (i % 4)
                0: begin f3 = 3'b000; ex = p[31:0]; end
                1: begin f3 = 3'b011; ex = p[63:32]; end
                2: begin f3 = 3'b101; ex = ra / rb; end
                default: begin f3 = 3'b111; ex = ra % rb; end
            endcase
            run_op(f3, ra, rb, ex, $sformatf("rnd%0d", i));
        end

        // Flush ten cycles into a divide
        run_op(3'b101, 32'd100, 32'd7, 32'd14, "pre_flush");
        bus.Funct3 = 3'b100;
        bus.SrcA   = 32'hFFFF_FFF9;
        bus.SrcB   = 32'd2;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 0);
        chk("flush_ready", bus.ready, 1);
        chk("flush_result", bus.Result, 14);
        quiet("flush", 40);
        chk("flush_result_hold", bus.Result, 14);

        // Reset ten cycles into a divide
        bus.Funct3 = 3'b100;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_result", bus.Result, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        quiet("midrst", 40);

        // Back-to-back start in FIN; start during CALC ignored
        wait_ready("b2b");
        bus.Funct3 = 3'b000;
        bus.SrcA   = 32'd3;
        bus.SrcB   = 32'd4;
        bus.start  = 1'b1;
        sbq.push_back('{32'd12, cyc, exp_lat(3'b000, 32'd3, 32'd4)});
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b_mul");
        chk("b2b_fin_ready", bus.ready, 1);
        bus.Funct3 = 3'b101;
        bus.SrcA   = 32'd9;
        bus.SrcB   = 32'd2;
        bus.start  = 1'b1;
        sbq.push_back('{32'd4, cyc, exp_lat(3'b101, 32'd9, 32'd2)});
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("calc_ready", bus.ready, 0);
        bus.Funct3 = 3'b000;
        bus.SrcA   = 32'd5;
        bus.SrcB   = 32'd5;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b_divu");
        @(negedge clk);
        quiet("b2b_tail", 40);

        // Flush coincident with done: start ignored, unit idles
        bus.Funct3 = 3'b000;
        bus.SrcA   = 32'd3;
        bus.SrcB   = 32'd4;
        bus.start  = 1'b1;
        sbq.push_back('{32'd12, cyc, exp_lat(3'b000, 32'd3, 32'd4)});
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("fdone_mul");
        bus.flush  = 1'b1;
        bus.start  = 1'b1;
        bus.Funct3 = 3'b101;
        bus.SrcA   = 32'd9;
        bus.SrcB   = 32'd2;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        chk("fdone_busy", bus.busy, 0);
        chk("fdone_done", bus.done, 0);
        chk("fdone_result", bus.Result, 12);
        quiet("fdone", 40);

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
